// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift opcodes and datapath widths.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int SHAMT_W   = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ILL = 2'b11
  } shift_op_e;

endpackage

// File: rtl/sll.sv
// Combinational logical left shifter, shared by the ALU datapath.
module sll
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] i_a,
  input  logic [SHAMT_W-1:0]   i_shamt,
  output logic [ALU_WIDTH-1:0] o_y
);

  assign o_y = i_a << i_shamt;

endmodule

// File: rtl/alu_shift_stage.sv
// Registered shift stage: operand register feeding a small in-order result buffer.
// Latency 2 edges from accept to out_valid; in_ready drops only when S1 is held by a full buffer.
module alu_shift_stage
  import alu_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ALU_WIDTH-1:0] in_a,
  input  logic [SHAMT_W-1:0]   in_shamt,
  input  logic [1:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALU_WIDTH-1:0] out_result,
  output logic                 out_zero,
  output logic                 out_illegal,
  output logic [15:0]          ops_count
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  function automatic logic [ALU_WIDTH-1:0] bit_rev(input logic [ALU_WIDTH-1:0] v);
    logic [ALU_WIDTH-1:0] r;
    for (int i = 0; i < ALU_WIDTH; i++) r[i] = v[ALU_WIDTH-1-i];
    return r;
  endfunction

  logic                 r_s1_v;
  logic [ALU_WIDTH-1:0] r_a;
  logic [SHAMT_W-1:0]   r_shamt;
  shift_op_e            r_op;

  logic [ALU_WIDTH-1:0] r_res_mem [OUT_DEPTH];
  logic                 r_zero_mem [OUT_DEPTH];
  logic                 r_ill_mem  [OUT_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [15:0]          r_ops_count;

  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [ALU_WIDTH-1:0] w_sll_in;
  logic [ALU_WIDTH-1:0] w_sll_data;
  logic [ALU_WIDTH-1:0] w_sll_mask;
  logic [ALU_WIDTH-1:0] w_srl;
  logic [ALU_WIDTH-1:0] w_sra_mask;
  logic [ALU_WIDTH-1:0] w_result;
  logic                 w_illegal;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_push    = r_s1_v && ((r_count < CNT_W'(OUT_DEPTH)) || w_pop);
  assign in_ready  = !r_s1_v || w_push;
  assign w_accept  = in_valid && in_ready;

  // Right shifts reuse the left shifter on the bit-reversed operand.
  assign w_sll_in = (r_op == SHIFT_SLL) ? r_a : bit_rev(r_a);

  sll u_sll_data (
    .i_a     (w_sll_in),
    .i_shamt (r_shamt),
    .o_y     (w_sll_data)
  );

  sll u_sll_mask (
    .i_a     ({ALU_WIDTH{1'b1}}),
    .i_shamt (r_shamt),
    .o_y     (w_sll_mask)
  );

  assign w_srl = bit_rev(w_sll_data);
  // rev(ones << shamt) keeps the low bits; its complement is the vacated top field.
  assign w_sra_mask = r_a[ALU_WIDTH-1] ? ~bit_rev(w_sll_mask) : '0;

  always_comb begin
    w_result  = r_a;
    w_illegal = 1'b0;
    case (r_op)
      SHIFT_SLL: w_result = w_sll_data;
      SHIFT_SRL: w_result = w_srl;
      SHIFT_SRA: w_result = w_srl | w_sra_mask;
      default:   w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v      <= 1'b0;
      r_a         <= '0;
      r_shamt     <= '0;
      r_op        <= SHIFT_SLL;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ops_count <= '0;
    end else begin
      if (w_accept) begin
        r_a     <= in_a;
        r_shamt <= in_shamt;
        r_op    <= shift_op_e'(in_op);
        if (r_ops_count != 16'hFFFF) r_ops_count <= r_ops_count + 16'd1;
      end
      if (w_accept)    r_s1_v <= 1'b1;
      else if (w_push) r_s1_v <= 1'b0;

      if (w_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_res_mem[r_wr_ptr]  <= w_result;
      r_zero_mem[r_wr_ptr] <= (w_result == '0);
      r_ill_mem[r_wr_ptr]  <= w_illegal;
    end
  end

  assign out_result  = out_valid ? r_res_mem[r_rd_ptr]  : '0;
  assign out_zero    = out_valid ? r_zero_mem[r_rd_ptr] : 1'b0;
  assign out_illegal = out_valid ? r_ill_mem[r_rd_ptr]  : 1'b0;
  assign ops_count   = r_ops_count;

endmodule

// File: tb/tb_alu_shift_stage.sv
// Scoreboard bench for alu_shift_stage: expected results queued at accept, checked at pop.
module tb_alu_shift_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;
  logic [15:0] ops_count;

  alu_shift_stage #(.OUT_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_shamt    (in_shamt),
    .in_op       (in_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal),
    .ops_count   (ops_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_stall  = 0;
  int          acc_cnt  = 0;
  logic [33:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [33:0] pk(input logic [31:0] res, input logic [1:0] op);
    return {res, (res == 32'd0), (op == 2'b11)};
  endfunction

  function automatic logic [33:0] model(input logic [31:0] a, input logic [4:0] s, input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'b00:   r = a << s;
      2'b01:   r = a >> s;
      2'b10:   r = 32'($signed(a) >>> s);
      default: r = a;
    endcase
    return pk(r, op);
  endfunction

  // Monitor: every pop must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("result", out_result, e[33:2]);
        chk("zero", 32'(out_zero), 32'(e[1]));
        chk("illegal", 32'(out_illegal), 32'(e[0]));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [4:0] s, input logic [1:0] op,
                      input logic [33:0] exp);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_shamt = s; in_op = op;
    @(negedge clk);
    if (!in_ready) n_stall++;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    else begin
      exp_q.push_back(exp);
      acc_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    chk("drain_empty", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    acc_cnt = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] head;
    logic [31:0] ra;
    logic [4:0]  rs;
    logic [1:0]  ro;

    rst_n = 1'b0; in_valid = 1'b1; in_a = 32'hDEADBEEF; in_shamt = 5'd3; in_op = 2'b00;
    out_ready = 1'b1;
    do_reset(3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ops_count", 32'(ops_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_result", out_result, 32'd0);

    // Basic ops, with an explicit latency probe on the first one.
    send(32'h00000001, 5'd4, 2'b00, pk(32'h00000010, 2'b00));
    chk("lat_after_n", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_after_n1", 32'(out_valid), 32'd1);
    send(32'h80000000, 5'd31, 2'b01, pk(32'h00000001, 2'b01));
    send(32'h80000000, 5'd31, 2'b10, pk(32'hFFFFFFFF, 2'b10));
    send(32'h40000000, 5'd30, 2'b10, pk(32'h00000001, 2'b10));
    drain();

    send(32'h00000001, 5'd31, 2'b00, pk(32'h80000000, 2'b00));
    send(32'hFFFFFFFF, 5'd0,  2'b00, pk(32'hFFFFFFFF, 2'b00));
    send(32'h00000000, 5'd5,  2'b01, pk(32'h00000000, 2'b01));
    send(32'h1234ABCD, 5'd7,  2'b11, pk(32'h1234ABCD, 2'b11));
    send(32'h87654321, 5'd0,  2'b10, pk(32'h87654321, 2'b10));
    drain();
    chk("ops_count_directed", 32'(ops_count), 32'(acc_cnt));

    // Backpressure: depth 2 holds two results plus one in S1.
    out_ready = 1'b0;
    send(32'h0000000F, 5'd1, 2'b00, pk(32'h0000001E, 2'b00));
    send(32'hF0000000, 5'd4, 2'b10, pk(32'hFF000000, 2'b10));
    send(32'h00FF0000, 5'd8, 2'b01, pk(32'h0000FF00, 2'b01));
    in_valid = 1'b1; in_a = 32'h12345678; in_shamt = 5'd16; in_op = 2'b00;
    @(negedge clk);
    chk("bp_stall", 32'(in_ready), 32'd0);
    head = out_result;
    repeat (3) @(negedge clk);
    chk("bp_hold_result", out_result, head);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_head_is_a", head, 32'h0000001E);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_rise", 32'(in_ready), 32'd1);
    exp_q.push_back(pk(32'h56780000, 2'b00));
    acc_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Full throughput against the reference model.
    do_reset(1);
    out_ready = 1'b1;
    n_stall   = 0;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rs = 5'($urandom_range(0, 31));
      ro = 2'($urandom_range(0, 3));
      send(ra, rs, ro, model(ra, rs, ro));
    end
    chk("tp_no_stall", 32'(n_stall), 32'd0);
    chk("tp_ops_count", 32'(ops_count), 32'd100);
    drain();

    // Reset with results in flight discards them.
    out_ready = 1'b0;
    send(32'hAAAA5555, 5'd3, 2'b00, model(32'hAAAA5555, 5'd3, 2'b00));
    send(32'h80000001, 5'd9, 2'b10, model(32'h80000001, 5'd9, 2'b10));
    send(32'h0F0F0F0F, 5'd2, 2'b01, model(32'h0F0F0F0F, 5'd2, 2'b01));
    do_reset(1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ops_count", 32'(ops_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(32'h00000003, 5'd2, 2'b00, pk(32'h0000000C, 2'b00));
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_quiet", 32'(out_valid), 32'd0);
    chk("mid_rst_count1", 32'(ops_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
